// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: loads a word on load&&ready, shifts it out
// MSB-first over WIDTH cycles, then idles for HOLD cycles before accepting again.
module piso_tx #(
    parameter int WIDTH = 4,
    parameter int HOLD  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             load,
    output logic             ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             busy,
    output logic             done
);

    localparam int MAXWH = (WIDTH > HOLD) ? WIDTH : HOLD;
    localparam int CW    = $clog2(MAXWH + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    localparam logic [CW-1:0] SHIFT_LOAD = CW'(WIDTH - 1);
    localparam logic [CW-1:0] HOLD_LOAD  = CW'((HOLD > 0) ? HOLD - 1 : 0);

    logic [1:0]       state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;

    // dout is the shift register MSB; clearing the register on return to IDLE
    // gives dout=0 there, while HOLD leaves it frozen on the last bit.
    assign dout = shreg[WIDTH-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            shreg      <= '0;
            cnt        <= '0;
            ready      <= 1'b0;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    ready <= 1'b1;
                    if (load && ready) begin
                        state      <= ST_SHIFT;
                        shreg      <= din;
                        cnt        <= SHIFT_LOAD;
                        ready      <= 1'b0;
                        dout_valid <= 1'b1;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (cnt != '0) begin
                        shreg <= {shreg[WIDTH-2:0], 1'b0};
                        cnt   <= cnt - CW'(1);
                        done  <= (cnt == CW'(1));
                    end else begin
                        done       <= 1'b0;
                        dout_valid <= 1'b0;
                        if (HOLD == 0) begin
                            state <= ST_IDLE;
                            shreg <= '0;
                            busy  <= 1'b0;
                            ready <= 1'b1;
                        end else begin
                            state <= ST_HOLD;
                            cnt   <= HOLD_LOAD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        state <= ST_IDLE;
                        shreg <= '0;
                        busy  <= 1'b0;
                        ready <= 1'b1;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    shreg      <= '0;
                    cnt        <= '0;
                    ready      <= 1'b0;
                    dout_valid <= 1'b0;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: three parameterisations against a frame-offset reference model,
// directed frames from the test plan followed by randomized load/din/reset traffic.
module tb_piso_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0, rst1, rst2;
    logic       load0, load1, load2;
    logic [3:0] din0, din1;
    logic [7:0] din2;
    logic       ready0, dout0, dv0, busy0, done0;
    logic       ready1, dout1, dv1, busy1, done1;
    logic       ready2, dout2, dv2, busy2, done2;

    piso_tx #(.WIDTH(4), .HOLD(4)) u0 (
        .clk(clk), .rst(rst0), .din(din0), .load(load0), .ready(ready0),
        .dout(dout0), .dout_valid(dv0), .busy(busy0), .done(done0)
    );
    piso_tx #(.WIDTH(4), .HOLD(0)) u1 (
        .clk(clk), .rst(rst1), .din(din1), .load(load1), .ready(ready1),
        .dout(dout1), .dout_valid(dv1), .busy(busy1), .done(done1)
    );
    piso_tx #(.WIDTH(8), .HOLD(2)) u2 (
        .clk(clk), .rst(rst2), .din(din2), .load(load2), .ready(ready2),
        .dout(dout2), .dout_valid(dv2), .busy(busy2), .done(done2)
    );

    // 4-stage serial capture register fed from u0
    logic [3:0] cap;
    always_ff @(posedge clk) begin
        if (dv0) cap <= {cap[2:0], dout0};
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Model: frame offset since the accepting edge (-1 when idle)
    int          mw[3] = '{4, 4, 8};
    int          mh[3] = '{4, 0, 2};
    bit          started[3];
    int          off[3];
    logic [31:0] word[3];

    function automatic logic cur_rst(input int i);
        return (i == 0) ? rst0 : (i == 1) ? rst1 : rst2;
    endfunction

    function automatic logic cur_load(input int i);
        return (i == 0) ? load0 : (i == 1) ? load1 : load2;
    endfunction

    function automatic logic [31:0] cur_din(input int i);
        return (i == 0) ? {28'd0, din0} : (i == 1) ? {28'd0, din1} : {24'd0, din2};
    endfunction

    function automatic logic [4:0] obs_out(input int i);
        if (i == 0) return {ready0, dout0, dv0, busy0, done0};
        if (i == 1) return {ready1, dout1, dv1, busy1, done1};
        return {ready2, dout2, dv2, busy2, done2};
    endfunction

    // {ready, dout, dout_valid, busy, done}
    function automatic logic [4:0] expect_out(input int i);
        logic [31:0] w;
        if (!cur_rst(i) || !started[i]) return 5'b00000;
        if (off[i] < 0) return 5'b10000;
        w = word[i];
        if (off[i] < mw[i])
            return {1'b0, w[mw[i]-1-off[i]], 1'b1, 1'b1, off[i] == mw[i] - 1};
        return {1'b0, w[0], 1'b0, 1'b1, 1'b0};
    endfunction

    task automatic check_all();
        for (int i = 0; i < 3; i++)
            chk($sformatf("u%0d@%0t", i, $time), {27'd0, obs_out(i)}, {27'd0, expect_out(i)});
    endtask

    task automatic tick();
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            if (!cur_rst(i)) begin
                started[i] = 1'b0;
                off[i]     = -1;
            end else if (!started[i]) begin
                started[i] = 1'b1;
            end else if (off[i] < 0) begin
                if (cur_load(i)) begin
                    off[i]  = 0;
                    word[i] = cur_din(i);
                end
            end else begin
                off[i]++;
                if (off[i] >= mw[i] + mh[i]) off[i] = -1;
            end
        end
        #1;
        check_all();
    endtask

    initial begin
        logic [2:0] rv;
        for (int i = 0; i < 3; i++) begin
            started[i] = 1'b0;
            off[i]     = -1;
            word[i]    = '0;
        end
        {rst2, rst1, rst0}    = 3'b111;
        {load2, load1, load0} = 3'b000;
        din0 = '0; din1 = '0; din2 = '0;
        #1 {rst2, rst1, rst0} = 3'b000;
        #1 check_all();
        tick();
        {rst2, rst1, rst0} = 3'b111;
        #1 check_all();
        tick();

        // Basic frame with load held while busy (u0), back-to-back HOLD=0 (u1), wide (u2)
        load0 = 1'b1; din0 = 4'b1011;
        load1 = 1'b1; din1 = 4'b1101;
        load2 = 1'b1; din2 = 8'hA5;
        tick();
        din0 = 4'b0100; din1 = 4'b0010; load2 = 1'b0;
        for (int t = 1; t <= 24; t++) begin
            tick();
            if (t >= 4 && t <= 8) chk("loopback", {28'd0, cap}, 32'hB);
        end

        // Asynchronous reset two bits into a frame
        load0 = 1'b0; load1 = 1'b0;
        repeat (10) tick();
        load0 = 1'b1; din0 = 4'b1011;
        tick();
        load0 = 1'b0;
        tick();
        rst0 = 1'b0;
        #1 check_all();
        chk("async_rst", {27'd0, ready0, dout0, dv0, busy0, done0}, 32'd0);
        tick();
        #2 rst0 = 1'b1;
        tick();
        chk("rst_ready", {31'd0, ready0}, 32'd1);
        repeat (5) tick();

        // Randomized traffic with occasional resets
        for (int n = 0; n < 400; n++) begin
            rv = {rst2, rst1, rst0};
            for (int i = 0; i < 3; i++) begin
                if (!rv[i]) rv[i] = 1'($urandom_range(0, 1));
                else if ($urandom_range(0, 39) == 0) rv[i] = 1'b0;
            end
            {rst2, rst1, rst0} = rv;
            load0 = ($urandom_range(0, 3) != 0);
            load1 = ($urandom_range(0, 3) != 0);
            load2 = ($urandom_range(0, 3) != 0);
            din0  = 4'($urandom);
            din1  = 4'($urandom);
            din2  = 8'($urandom);
            #1 check_all();
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/piso_tx.md
# piso_tx

Parallel-in serial-out transmitter that drives the serial link feeding the team's 4-bit serial capture register. A parallel word is accepted on a valid/ready load handshake, shifted out MSB-first one bit per clock, and followed by a fixed hold window before the next word can be loaded. This is the sending end of the shift-then-hold serial framing: WIDTH shift cycles followed by HOLD idle cycles.

## Interface

- WIDTH, 4: bits per frame; legal range 2..32.
- HOLD, 4: post-frame hold cycles; legal range 0..31.
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- din  in  WIDTH  parallel word to transmit; sampled only on an accepted load.
- load  in  1  load request (valid).
- ready  out  1  high when a load will be accepted this cycle.
- dout  out  1  serial data, MSB first.
- dout_valid  out  1  high while dout carries a frame bit.
- busy  out  1  high in SHIFT or HOLD.
- done  out  1  one-cycle pulse while the last bit (din[0]) is on dout.

## Operation

- States:
  - IDLE: ready=1, dout=0, dout_valid=0, busy=0.
  - SHIFT: WIDTH cycles, one bit per cycle.
  - HOLD: HOLD cycles, dout_valid=0, dout frozen at the last transmitted bit.
- Transitions:
  - IDLE -> SHIFT on load&&ready at a rising edge; din is copied to the shift register.
  - SHIFT -> HOLD after the WIDTH-th bit; if HOLD=0, SHIFT -> IDLE directly.
  - HOLD -> IDLE after HOLD cycles.
- Shift register: left shift. dout is the register MSB (registered output, no combinational path from din or load).
- Counter: a single down-counter, width $clog2(max(WIDTH,HOLD)+1). It is reused for SHIFT and HOLD and reloaded on each state entry. It never wraps.
- load while ready=0 is ignored. din changes while busy have no effect on the frame in flight.
- All outputs are registered, including ready, done and busy.
- Reset (rst=0, any time, including mid-frame): state=IDLE, shift register=0, counter=0, dout=0, dout_valid=0, busy=0, done=0, ready=0. The frame in progress is discarded and is not resumed. ready rises at the first rising edge after rst returns to 1. load is ignored while rst=0 and on that first edge.

## Timing

- Load accepted at edge k.
- After edge k+i, for i = 0..WIDTH-1: dout = din[WIDTH-1-i] and dout_valid=1. done=1 only for i = WIDTH-1.
- After edges k+WIDTH .. k+WIDTH+HOLD-1: HOLD state. dout = din[0], dout_valid=0, busy=1.
- After edge k+WIDTH+HOLD: IDLE, ready=1, dout=0.
- Earliest next accept is edge k+WIDTH+HOLD+1. Minimum frame period is WIDTH+HOLD+1 cycles, because at least one IDLE cycle sits between frames.
- Latency from load to first bit on dout: 1 cycle.
- ready falls at edge k, the same edge that accepts the load. A load held high continuously is accepted exactly once per period.

## Test plan

- Reset: pull rst=0 mid-SHIFT (WIDTH=4, HOLD=4, word 4'b1011, after 2 bits). dout, dout_valid, busy, done and ready go to 0 immediately without a clock edge. After release: ready=1 one edge later, dout stays 0, and no residual bits appear.
- Basic frame, WIDTH=4, HOLD=4, load 4'b1011 at edge k: dout = 1,0,1,1 with dout_valid=1, and done only on the 4th bit. Then 4 cycles of dout=1 with dout_valid=0. ready=1 after edge k+8.
- Load while busy: during the frame for 4'b1011, assert load with din=4'b0100 on every cycle. The output stream is unchanged. After returning to IDLE, the held load is accepted and 0,1,0,0 is sent.
- Back-to-back, HOLD=0: keep load high with 4'b1101 then 4'b0010. Output is 1,1,0,1, one IDLE cycle with dout=0, then 0,0,1,0. done pulses twice, 5 cycles apart.
- Loopback: drive dout into a 4-stage serial-in capture register clocked by the same clk, sending word 4'b1011. After the 4 dout_valid cycles, the capture register holds 4'b1011 and stays stable through HOLD.
- Wide parameters, WIDTH=8, HOLD=2, load 8'hA5: dout = 1,0,1,0,0,1,0,1, done on the 8th bit, 2 hold cycles with dout=1. ready=1 after edge k+10, and the counter never wraps.
